// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrgood_mon.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__pwrgood_mon
//
// Behavioural supply-rail monitor for the 7-track 5V library. The sensed
// VDD/VSS rails are brought into the CLK domain through two-flop
// synchronisers, then qualified by a settle FSM. PWRGOOD rises only after
// SETTLE_CYCLES consecutive good samples. Every dropout (a bad rail while
// settling or good) is counted, and reaching MAX_GLITCH dropouts latches
// a sticky FAULT that only RST clears.
//
// Parameters:
//   SETTLE_CYCLES  consecutive good samples before PWRGOOD (1..65536)
//   CNT_W          width of GLITCH_CNT
//   MAX_GLITCH     dropout count that forces FAULT (1..2^CNT_W-1)
//
// Ports:
//   CLK         in   1      clock, rising edge
//   RST         in   1      synchronous reset, active-high, top priority
//   EN          in   1      monitor enable; low forces OFF except in FAULT
//   VDD         in   1      sensed supply rail (logic level)
//   VSS         in   1      sensed ground rail (logic level)
//   PWRGOOD     out  1      rails qualified (dedicated flop)
//   FAULT       out  1      sticky dropout-limit fault
//   STATE       out  2      00 OFF, 01 SETTLE, 10 GOOD, 11 FAULT
//   GLITCH_CNT  out  CNT_W  dropouts since reset, saturating
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__pwrgood_mon #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int MAX_GLITCH    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             VDD,
    input  logic             VSS,
    output logic             PWRGOOD,
    output logic             FAULT,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] GLITCH_CNT
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GLITCH_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GLITCH_LIM  = CNT_W'(MAX_GLITCH);

    // Reject illegal parameterisations at elaboration time.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65536) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range 1..65536");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
    if (MAX_GLITCH < 1 || MAX_GLITCH > (2 ** CNT_W) - 1) begin : g_bad_max
        $error("MAX_GLITCH out of range 1..2^CNT_W-1");
    end

    // -----------------------------------------------------------------------
    // State encoding: the register value is driven directly onto STATE.
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_SETTLE = 2'b01,
        ST_GOOD   = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_cnt_nxt;
    logic             pwrgood_nxt;
    logic             fault_nxt;
    logic [CNT_W-1:0] glitch_nxt;
    logic [CNT_W-1:0] glitch_inc;
    logic             glitch_limit;
    logic             dropout;

    // -----------------------------------------------------------------------
    // Rail synchronisers: two flops per rail.
    // -----------------------------------------------------------------------
    logic vdd_s1;
    logic vdd_s2;
    logic vss_s1;
    logic vss_s2;
    logic rail_ok;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments let every flop sample the old value
        // of its neighbour, which is what makes this a two-stage chain.
        if (RST) begin
            vdd_s1 <= 1'b0;
            vdd_s2 <= 1'b0;
            vss_s1 <= 1'b0;
            vss_s2 <= 1'b0;
        end else begin
            vdd_s1 <= VDD;
            vdd_s2 <= vdd_s1;
            vss_s1 <= VSS;
            vss_s2 <= vss_s1;
        end
    end

    // NOTE: case-equality makes an X or Z on either rail read as "bad" in
    // simulation instead of silently passing; hardware sees plain equality.
    assign rail_ok = (vdd_s2 === 1'b1) && (vss_s2 === 1'b0);

    // -----------------------------------------------------------------------
    // Dropout bookkeeping: saturating increment and fault-limit compare.
    // -----------------------------------------------------------------------
    assign glitch_inc   = (GLITCH_CNT == GLITCH_SAT) ? GLITCH_CNT
                                                     : GLITCH_CNT + CNT_W'(1);
    assign glitch_limit = (glitch_inc >= GLITCH_LIM);

    // -----------------------------------------------------------------------
    // Next-state / next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a hold value first so no path through the
        // case leaves one unassigned, which would infer a latch.
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        pwrgood_nxt    = PWRGOOD;
        fault_nxt      = FAULT;
        glitch_nxt     = GLITCH_CNT;
        dropout        = 1'b0;

        unique case (state)
            ST_OFF: begin
                pwrgood_nxt = 1'b0;
                if (EN && rail_ok) begin
                    state_nxt      = ST_SETTLE;
                    settle_cnt_nxt = '0;
                end
            end

            ST_SETTLE: begin
                if (!EN) begin
                    // Disable wins over a simultaneous dropout: no count.
                    state_nxt      = ST_OFF;
                    settle_cnt_nxt = '0;
                    pwrgood_nxt    = 1'b0;
                end else if (rail_ok) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt   = ST_GOOD;
                        pwrgood_nxt = 1'b1;
                    end else begin
                        settle_cnt_nxt = settle_cnt + SET_W'(1);
                    end
                end else begin
                    dropout = 1'b1;
                end
            end

            ST_GOOD: begin
                if (!EN) begin
                    state_nxt      = ST_OFF;
                    settle_cnt_nxt = '0;
                    pwrgood_nxt    = 1'b0;
                end else if (!rail_ok) begin
                    dropout = 1'b1;
                end
            end

            ST_FAULT: begin
                // Sticky: EN and the rails are ignored, the counter freezes.
                pwrgood_nxt = 1'b0;
                fault_nxt   = 1'b1;
            end

            default: begin
                state_nxt = ST_OFF;
            end
        endcase

        // A dropout restarts the settle window, or ends in FAULT once the
        // incremented count reaches the limit.
        if (dropout) begin
            glitch_nxt     = glitch_inc;
            settle_cnt_nxt = '0;
            pwrgood_nxt    = 1'b0;
            if (glitch_limit) begin
                state_nxt = ST_FAULT;
                fault_nxt = 1'b1;
            end else begin
                state_nxt = ST_SETTLE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            PWRGOOD    <= 1'b0;
            FAULT      <= 1'b0;
            GLITCH_CNT <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            PWRGOOD    <= pwrgood_nxt;
            FAULT      <= fault_nxt;
            GLITCH_CNT <= glitch_nxt;
        end
    end

    assign STATE = state;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__pwrgood_mon.md
Name: gf180mcu_fd_sc_mcu7t5v0__pwrgood_mon

Overview:
Behavioural supply-rail monitor for the 7-track 5V library. Filler and tap cells only tie VDD/VSS passively; this block senses those rails as logic levels and qualifies them. It synchronises and debounces the rail state and asserts PWRGOOD after a stable settle window. It counts dropouts and latches FAULT after too many.

Parameters:
SETTLE_CYCLES, 16, consecutive good synchronised samples required before PWRGOOD; legal range 1..65536; settle counter width is $clog2(SETTLE_CYCLES)+1.
CNT_W, 8, width of GLITCH_CNT.
MAX_GLITCH, 3, dropout count that forces FAULT; legal range 1..2^CNT_W-1.

Ports:
CLK  input  1  single clock, rising edge.
RST  input  1  synchronous reset, active-high.
EN  input  1  monitor enable; low forces OFF, except from FAULT.
VDD  input  1  sensed supply rail, logic level.
VSS  input  1  sensed ground rail, logic level.
PWRGOOD  output  1  rails qualified; dedicated flop.
FAULT  output  1  sticky dropout-limit fault.
STATE  output  2  00 OFF, 01 SETTLE, 10 GOOD, 11 FAULT.
GLITCH_CNT  output  CNT_W  dropouts since reset; saturating.

Behaviour:
- Reset (RST=1 at an edge): state OFF, PWRGOOD=0, FAULT=0, GLITCH_CNT=0, settle counter=0, both synchroniser stages=0. RST has priority over everything, including in mid-SETTLE and in FAULT.
- Synchroniser: 2 flops per rail. rail_ok = (vdd_s2===1) && (vss_s2===0). X or Z on a rail counts as bad.
- OFF: if EN && rail_ok, go to SETTLE with cnt=0 on the next edge. Otherwise stay.
- SETTLE, rail_ok=1: if cnt==SETTLE_CYCLES-1, go to GOOD and set PWRGOOD=1 on the same edge. Otherwise cnt+1.
- SETTLE, rail_ok=0: cnt=0, stay in SETTLE, count a dropout.
- GOOD, rail_ok=0: go to SETTLE, cnt=0, PWRGOOD=0 on the same edge, count a dropout.
- Dropout counting: GLITCH_CNT increments and saturates at 2^CNT_W-1. If the incremented value is >= MAX_GLITCH, go to FAULT on that edge, FAULT=1, PWRGOOD=0.
- FAULT: sticky. Ignores EN and the rails. Left only by RST. GLITCH_CNT is frozen.
- EN=0 in OFF, SETTLE or GOOD: next edge goes to OFF, PWRGOOD=0, cnt=0, GLITCH_CNT holds. EN=0 has priority over a simultaneous dropout, so no increment on that edge.
- Latency, rails good and EN high from before edge 1: sync complete at edge 2, SETTLE at edge 3, GOOD and PWRGOOD=1 at edge 3+SETTLE_CYCLES (edge 19 by default).
- Dropout latency: a bad rail sampled at edge k deasserts PWRGOOD at edge k+2.
- A one-cycle bad pulse costs exactly one dropout, then the full SETTLE_CYCLES window again.
- STATE is a direct encoding of the state register. All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
1. Nominal power-up: RST 2 cycles, then EN=1, VDD=1, VSS=0 held. PWRGOOD=0 through edge 18. PWRGOOD=1 and STATE=10 from edge 19. GLITCH_CNT=0.
2. Single dropout: in GOOD, VDD=0 for one cycle sampled at edge k. PWRGOOD=0 and STATE=01 at edge k+2, GLITCH_CNT=1. PWRGOOD=1 again at edge k+2+16.
3. Fault limit: three separate dropouts. On the third, STATE=11, FAULT=1, PWRGOOD=0, GLITCH_CNT=3. Toggling EN and restoring the rails changes nothing. One RST edge returns all outputs to 0 and STATE to 00.
4. Unknown rail: EN=1, VSS=0, VDD=X held for 40 cycles. STATE stays 00 and PWRGOOD=0. Setting VDD=1 reaches GOOD 19 edges later.
5. Enable drop: in GOOD with GLITCH_CNT=2, drive EN=0 together with VDD=0. Next edge gives STATE=00, PWRGOOD=0, GLITCH_CNT still 2, FAULT=0.
6. Reset mid-settle: RST at the 10th SETTLE cycle. Next edge has all outputs 0. The full 19-edge latency is needed again after RST is released.
